relu_stream_arbiter: RTL and testbench

// - Shares one ReLu/saturation stage among NUM_CH convolution-channel accumulator streams.
// - Grants are packet-granular and round-robin. A granted channel owns the stage from its
//   sop beat through its eop beat.
// - Produces one registered, framed stream (sop/eop/sof/eof) with a channel tag.
// - Sits between the per-channel MAC accumulators and the shared ReLu stage.
//   The ReLu stage has no backpressure, so this block issues at most 1 beat/cycle.
//

---
 rtl/relu_stream_arbiter.sv | 136 +++++++++++++
 tb/tb_relu_stream_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_stream_arbiter.sv
// relu_stream_arbiter
// Packet-granular round-robin arbiter that merges NUM_CH framed accumulator
// streams into one registered stream for a shared ReLu/saturation stage.
// A channel wins on its sop beat and keeps the stage until its eop beat;
// at most one beat is issued per cycle because the ReLu stage cannot stall.
module relu_stream_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 24,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data_i,
  input  logic [NUM_CH-1:0]            in_valid_i,
  input  logic [NUM_CH-1:0]            in_sop_i,
  input  logic [NUM_CH-1:0]            in_eop_i,
  input  logic [NUM_CH-1:0]            in_sof_i,
  input  logic [NUM_CH-1:0]            in_eof_i,
  output logic [NUM_CH-1:0]            in_ready_o,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic                         out_valid_o,
  output logic                         out_sop_o,
  output logic                         out_eop_o,
  output logic                         out_sof_o,
  output logic                         out_eof_o,
  output logic [CH_W-1:0]              out_ch_o,
  output logic                         proto_err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state;
  logic [CH_W-1:0]       grant;       // channel that owns the stage while BUSY
  logic [CH_W-1:0]       last;        // most recent winner; search starts after it
  logic [CH_W-1:0]       pick;
  logic [CH_W-1:0]       rr_idx;
  logic [CH_W-1:0]       sel;
  logic                  pick_found;
  logic                  xfer;
  logic                  stray_beat;
  logic [NUM_CH-1:0]     sop_req;
  logic [DATA_WIDTH-1:0] sel_data;

  assign sop_req    = in_valid_i & in_sop_i;
  assign stray_beat = |(in_valid_i & ~in_sop_i);
  assign sel_data   = in_data_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

  // Cyclic search for the first sop request after the previous winner.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise a path that skips the assignment infers a latch.
    pick       = last;
    pick_found = 1'b0;
    rr_idx     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      rr_idx = CH_W'((int'(last) + k) % NUM_CH);
      if (!pick_found && sop_req[rr_idx]) begin
        pick_found = 1'b1;
        pick       = rr_idx;
      end
    end
  end

  // Ready, beat select and transfer qualifier; depends only on arbiter state and
  // the valid/sop inputs, never on the output register.
  always_comb begin
    in_ready_o = '0;
    sel        = grant;
    xfer       = 1'b0;
    if (state == IDLE) begin
      sel  = pick;
      xfer = pick_found;
      // Ready is masked while reset is asserted so no upstream beat is
      // consumed by a block whose registers are being held clear.
      if (pick_found) in_ready_o[pick] = reset_n;
    end else begin
      xfer              = in_valid_i[grant];
      in_ready_o[grant] = reset_n;
    end
  end

  // Arbiter FSM, registered output beat and sticky protocol error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= '0;
      last        <= CH_W'(NUM_CH - 1);
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      out_sop_o   <= 1'b0;
      out_eop_o   <= 1'b0;
      out_sof_o   <= 1'b0;
      out_eof_o   <= 1'b0;
      out_ch_o    <= '0;
      proto_err_o <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      out_valid_o <= xfer;
      out_sop_o   <= xfer & in_sop_i[sel];
      out_eop_o   <= xfer & in_eop_i[sel];
      out_sof_o   <= xfer & in_sof_i[sel];
      out_eof_o   <= xfer & in_eof_i[sel];
      // Data and tag hold their last value across idle cycles.
      if (xfer) begin
        out_data_o <= sel_data;
        out_ch_o   <= sel;
      end

      case (state)
        IDLE: begin
          // A valid beat without sop cannot start a packet; it is held and flagged.
          if (stray_beat) proto_err_o <= 1'b1;
          if (pick_found) begin
            grant <= pick;
            last  <= pick;
            // A single-beat packet ends in the same cycle it is granted.
            if (!in_eop_i[pick]) state <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) begin
            // A second sop inside the packet is forwarded but flagged.
            if (in_sop_i[grant]) proto_err_o <= 1'b1;
            if (in_eop_i[grant]) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_stream_arbiter.sv
// Testbench for relu_stream_arbiter: per-channel beat queues feed the DUT, a
// packet-level round-robin model predicts ready and the output beats, and a
// separate monitor compares the registered output stream against the queue.
module tb_relu_stream_arbiter;

  localparam int NUM_CH = 4;
  localparam int DW     = 24;
  localparam int CH_W   = 2;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic [NUM_CH*DW-1:0]    in_data_i;
  logic [NUM_CH-1:0]       in_valid_i, in_sop_i, in_eop_i, in_sof_i, in_eof_i;
  logic [NUM_CH-1:0]       in_ready_o;
  logic [DW-1:0]           out_data_o;
  logic                    out_valid_o, out_sop_o, out_eop_o, out_sof_o, out_eof_o;
  logic [CH_W-1:0]         out_ch_o;
  logic                    proto_err_o;

  relu_stream_arbiter #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_sop_i   (in_sop_i),
    .in_eop_i   (in_eop_i),
    .in_sof_i   (in_sof_i),
    .in_eof_i   (in_eof_i),
    .in_ready_o (in_ready_o),
    .out_data_o (out_data_o),
    .out_valid_o(out_valid_o),
    .out_sop_o  (out_sop_o),
    .out_eop_o  (out_eop_o),
    .out_sof_o  (out_sof_o),
    .out_eof_o  (out_eof_o),
    .out_ch_o   (out_ch_o),
    .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  // One slot per cycle of a channel's stimulus: either an idle cycle or a beat.
  typedef struct packed {
    logic          idle;
    logic [DW-1:0] data;
    logic          sop, eop, sof, eof;
  } slot_t;

  // Expected output beat and the cycle in which it must appear.
  typedef struct packed {
    logic [31:0]     due;
    logic [DW-1:0]   data;
    logic [CH_W-1:0] ch;
    logic            sop, eop, sof, eof;
  } exp_t;

  slot_t         ch_q [NUM_CH][$];
  exp_t          exp_q[$];
  int            seen_ch[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  bit            mon_en  = 1'b0;

  // Reference model state: owning channel (-1 = none), last winner, sticky error.
  int            m_owner = -1;
  int            m_last  = NUM_CH - 1;
  bit            m_err   = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic [CH_W-1:0] hold_ch = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic slot_t mk_beat(input logic [DW-1:0] d, input logic sop, input logic eop,
                                    input logic sof, input logic eof);
    slot_t s;
    s      = '0;
    s.data = d;
    s.sop  = sop;
    s.eop  = eop;
    s.sof  = sof;
    s.eof  = eof;
    return s;
  endfunction

  function automatic slot_t mk_gap();
    slot_t s;
    s      = '0;
    s.idle = 1'b1;
    return s;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [31:0] r;
    r = $urandom;
    return r[DW-1:0];
  endfunction

  function automatic bit stim_pending();
    for (int c = 0; c < NUM_CH; c++)
      if (ch_q[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_inputs();
    in_data_i  = '0;
    in_valid_i = '0;
    in_sop_i   = '0;
    in_eop_i   = '0;
    in_sof_i   = '0;
    in_eof_i   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q[c].size() > 0 && !ch_q[c][0].idle) begin
        in_valid_i[c]          = 1'b1;
        in_data_i[c*DW +: DW]  = ch_q[c][0].data;
        in_sop_i[c]            = ch_q[c][0].sop;
        in_eop_i[c]            = ch_q[c][0].eop;
        in_sof_i[c]            = ch_q[c][0].sof;
        in_eof_i[c]            = ch_q[c][0].eof;
      end
    end
  endtask

  // Packet-level arbitration model: predicts ready for this cycle, records the
  // beat that moves, and returns the model state for after the clock edge.
  task automatic model_eval(output logic [NUM_CH-1:0] xfer, output int n_owner,
                            output int n_last, output bit n_err);
    logic [NUM_CH-1:0] rdy;
    int   c_sel;
    exp_t e;
    rdy     = '0;
    xfer    = '0;
    c_sel   = -1;
    n_owner = m_owner;
    n_last  = m_last;
    n_err   = m_err;
    if (m_owner < 0) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        int c;
        c = (m_last + k) % NUM_CH;
        if (c_sel < 0 && in_valid_i[c] && in_sop_i[c]) c_sel = c;
      end
      for (int c = 0; c < NUM_CH; c++)
        if (in_valid_i[c] && !in_sop_i[c]) n_err = 1'b1;
      if (c_sel >= 0) begin
        rdy[c_sel] = 1'b1;
        n_last     = c_sel;
        n_owner    = in_eop_i[c_sel] ? -1 : c_sel;
      end
    end else begin
      rdy[m_owner] = 1'b1;
      if (in_valid_i[m_owner]) begin
        c_sel = m_owner;
        if (in_sop_i[c_sel]) n_err = 1'b1;
        if (in_eop_i[c_sel]) n_owner = -1;
      end
    end
    check("in_ready", 64'(in_ready_o), 64'(rdy));
    if (c_sel >= 0) begin
      xfer[c_sel] = 1'b1;
      e.due  = 32'(cyc + 1);
      e.data = in_data_i[c_sel*DW +: DW];
      e.ch   = CH_W'(c_sel);
      e.sop  = in_sop_i[c_sel];
      e.eop  = in_eop_i[c_sel];
      e.sof  = in_sof_i[c_sel];
      e.eof  = in_eof_i[c_sel];
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    logic [NUM_CH-1:0] x;
    int no, nl;
    bit ne;
    drive_inputs();
    @(negedge clk);
    model_eval(x, no, nl, ne);
    @(posedge clk);
    cyc++;
    m_owner = no;
    m_last  = nl;
    m_err   = ne;
    #1;
    for (int c = 0; c < NUM_CH; c++)
      if (ch_q[c].size() > 0 && (ch_q[c][0].idle || x[c])) void'(ch_q[c].pop_front());
  endtask

  task automatic run_drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (stim_pending() && n < max_cycles) begin
      step();
      n++;
    end
    if (stim_pending()) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: stimulus still pending after %0d cycles", tag, max_cycles);
      for (int c = 0; c < NUM_CH; c++) ch_q[c].delete();
    end
    repeat (2) step();
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_last    = NUM_CH - 1;
    m_err     = 1'b0;
    hold_data = '0;
    hold_ch   = '0;
    exp_q.delete();
    for (int c = 0; c < NUM_CH; c++) ch_q[c].delete();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out"}, 64'({out_data_o, out_ch_o, out_valid_o, out_sop_o, out_eop_o,
                              out_sof_o, out_eof_o}), 64'(0));
    check({tag, "_ready"}, 64'(in_ready_o), 64'(0));
    check({tag, "_err"}, 64'(proto_err_o), 64'(0));
  endtask

  task automatic add_random_packets(input int c);
    int npk, len;
    npk = $urandom_range(1, 3);
    for (int p = 0; p < npk; p++) begin
      repeat ($urandom_range(0, 2)) ch_q[c].push_back(mk_gap());
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        if (b > 0 && $urandom_range(0, 3) == 0) ch_q[c].push_back(mk_gap());
        ch_q[c].push_back(mk_beat(rnd_data(), b == 0, b == len - 1,
                                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
      end
    end
  endtask

  // Output monitor: every cycle the registered stream must match the oldest
  // expected beat that is due now, or be idle with data/tag held.
  always @(negedge clk) begin
    exp_t e;
    bit   due;
    if (mon_en) begin
      due = (exp_q.size() > 0) && (exp_q[0].due == 32'(cyc));
      check("out_valid", 64'(out_valid_o), 64'(due));
      if (due) begin
        e = exp_q.pop_front();
        if (out_valid_o)
          check("out_beat",
                64'({out_data_o, out_ch_o, out_sop_o, out_eop_o, out_sof_o, out_eof_o}),
                64'({e.data, e.ch, e.sop, e.eop, e.sof, e.eof}));
        hold_data = e.data;
        hold_ch   = e.ch;
      end else begin
        check("idle_flags", 64'({out_sop_o, out_eop_o, out_sof_o, out_eof_o}), 64'(0));
        check("idle_hold", 64'({out_data_o, out_ch_o}), 64'({hold_data, hold_ch}));
      end
      if (out_valid_o) seen_ch.push_back(int'(out_ch_o));
      check("proto_err", 64'(proto_err_o), 64'(m_err));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rot_exp[6];

    // Reset held with every input active.
    reset_n    = 1'b0;
    in_data_i  = '1;
    in_valid_i = '1;
    in_sop_i   = '1;
    in_eop_i   = '1;
    in_sof_i   = '1;
    in_eof_i   = '1;
    repeat (3) @(posedge clk);
    #2;
    check_cleared("reset");
    model_reset();
    drive_inputs();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Single channel: ch2 sends A,B,C.
    ch_q[2].push_back(mk_beat(24'h00000A, 1'b1, 1'b0, 1'b1, 1'b0));
    ch_q[2].push_back(mk_beat(24'h00000B, 1'b0, 1'b0, 1'b0, 1'b0));
    ch_q[2].push_back(mk_beat(24'h00000C, 1'b0, 1'b1, 1'b0, 1'b1));
    run_drain("single", 50);

    // Contention: ch0 and ch1 present sop together.
    ch_q[0].push_back(mk_beat(24'h100001, 1'b1, 1'b0, 1'b0, 1'b0));
    ch_q[0].push_back(mk_beat(24'h100002, 1'b0, 1'b1, 1'b0, 1'b0));
    ch_q[1].push_back(mk_beat(24'h110001, 1'b1, 1'b0, 1'b0, 1'b0));
    ch_q[1].push_back(mk_beat(24'h110002, 1'b0, 1'b1, 1'b0, 1'b0));
    run_drain("contention", 50);

    // Gap lock: ch1 pauses two cycles while ch3 waits with sop.
    ch_q[1].push_back(mk_beat(24'h210001, 1'b1, 1'b0, 1'b0, 1'b0));
    ch_q[1].push_back(mk_gap());
    ch_q[1].push_back(mk_gap());
    ch_q[1].push_back(mk_beat(24'h210002, 1'b0, 1'b0, 1'b0, 1'b0));
    ch_q[1].push_back(mk_beat(24'h210003, 1'b0, 1'b1, 1'b0, 1'b0));
    ch_q[3].push_back(mk_gap());
    ch_q[3].push_back(mk_beat(24'h230001, 1'b1, 1'b1, 1'b0, 1'b0));
    run_drain("gap", 50);

    // Rotation: back-to-back single-beat packets on all channels.
    seen_ch.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NUM_CH; c++)
        ch_q[c].push_back(mk_beat(rnd_data(), 1'b1, 1'b1, 1'b0, 1'b0));
    run_drain("rotation", 50);
    rot_exp = '{0, 1, 2, 3, 0, 1};
    check("rotation_count", 64'(seen_ch.size()), 64'(8));
    for (int i = 0; i < 6; i++)
      if (i < seen_ch.size()) check("rotation_order", 64'(seen_ch[i]), 64'(rot_exp[i]));

    // Randomized traffic on all channels.
    for (int round = 0; round < 6; round++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 3) != 0) add_random_packets(c);
      run_drain("random", 2000);
    end

    // Second sop inside a packet sets the sticky error.
    ch_q[0].push_back(mk_beat(24'h300001, 1'b1, 1'b0, 1'b0, 1'b0));
    ch_q[0].push_back(mk_beat(24'h300002, 1'b1, 1'b0, 1'b0, 1'b0));
    ch_q[0].push_back(mk_beat(24'h300003, 1'b0, 1'b1, 1'b0, 1'b0));
    run_drain("error", 50);
    repeat (3) step();
    check("error_sticky", 64'(proto_err_o), 64'(1));

    // Reset in the middle of a ch2 packet.
    for (int b = 0; b < 6; b++)
      ch_q[2].push_back(mk_beat(rnd_data(), b == 0, b == 5, 1'b0, 1'b0));
    repeat (3) step();
    drive_inputs();
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #2;
    check_cleared("midreset");
    model_reset();
    drive_inputs();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    seen_ch.delete();
    ch_q[3].push_back(mk_beat(24'h430001, 1'b1, 1'b1, 1'b0, 1'b0));
    ch_q[0].push_back(mk_beat(24'h400001, 1'b1, 1'b1, 1'b0, 1'b0));
    run_drain("postreset", 50);
    check("postreset_count", 64'(seen_ch.size()), 64'(2));
    if (seen_ch.size() > 0) check("postreset_first", 64'(seen_ch[0]), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
